// File: rtl/dot_matrix_scan_capture_if.sv
// Scan-side and read-side signal bundle of the dot-matrix capture block.
// The driver (or bench) holds the master view; the capture block holds the slave view.
interface dot_matrix_scan_capture_if;
  logic [3:0]  column_seg;
  logic [15:0] in_column;
  logic        COLUMN_CLK;
  logic        OUT_CLR;
  logic        ERR_CLR;
  logic [3:0]  rd_column;
  logic [15:0] rd_data;
  logic        FRAME_DONE;
  logic [7:0]  frame_cnt;
  logic        SEQ_ERR;
  logic        STALL;
  logic        BUSY;

  modport master (
    output column_seg, in_column, COLUMN_CLK, OUT_CLR, ERR_CLR, rd_column,
    input  rd_data, FRAME_DONE, frame_cnt, SEQ_ERR, STALL, BUSY
  );

  modport slave (
    input  column_seg, in_column, COLUMN_CLK, OUT_CLR, ERR_CLR, rd_column,
    output rd_data, FRAME_DONE, frame_cnt, SEQ_ERR, STALL, BUSY
  );
endinterface

// File: rtl/dot_matrix_scan_capture.sv
// Display-side capture of the 16x16 dot-matrix column scan.
// Columns arrive one per COLUMN_CLK rising edge into a shadow buffer; when the
// last column lands the whole frame is copied to the committed buffer, which is
// what the registered read port exposes. Ordering and strobe-timeout problems
// are reported through sticky flags.
module dot_matrix_scan_capture #(
  parameter int COLS    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dot_matrix_scan_capture_if.slave bus
);

  localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLAST    = TW'(TIMEOUT - 1);
  localparam logic [3:0]     LAST_COL = 4'(COLS - 1);
  localparam logic [4:0]     NCOLS    = 5'(COLS);

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  state_t        state, state_next;
  logic [3:0]    expected, expected_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          col_clk_q;

  logic [15:0]   shadow    [16];
  logic [15:0]   committed [16];

  logic [15:0]   rd_q;
  logic          done_q;
  logic [7:0]    cnt_q;
  logic          seq_q;
  logic          stall_q;

  logic          strobe;
  logic          in_range;
  logic [15:0]   word;
  logic          wr_en;
  logic          commit;
  logic          seq_set;
  logic          stall_set;

  // The strobe is a level; only its rising edge carries a column.
  assign strobe   = bus.COLUMN_CLK & ~col_clk_q;
  assign word     = bus.OUT_CLR ? 16'h0000 : bus.in_column;
  assign in_range = {1'b0, bus.column_seg} < NCOLS;

  // Next-state decode: column acceptance, commit, error and timeout decisions.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    tcnt_next     = tcnt;
    wr_en         = 1'b0;
    commit        = 1'b0;
    seq_set       = 1'b0;
    stall_set     = 1'b0;

    if (strobe) begin
      tcnt_next = '0;
      if (state == IDLE) begin
        // Only column 0 starts a frame; anything else is silently skipped so
        // the capture resynchronises to the next frame start.
        if (bus.column_seg == 4'd0) begin
          wr_en      = 1'b1;
          state_next = CAPTURE;
        end
      end else if (in_range && (bus.column_seg == expected)) begin
        wr_en = 1'b1;
      end else begin
        seq_set = 1'b1;
        if (bus.column_seg == 4'd0) begin
          // A fresh column 0 mid-frame is taken as the start of a new frame.
          wr_en = 1'b1;
        end else begin
          state_next    = IDLE;
          expected_next = '0;
        end
      end

      if (wr_en) begin
        if (bus.column_seg == LAST_COL) begin
          // Stay in CAPTURE with expected=0 so the next frame can follow
          // back-to-back.
          commit        = 1'b1;
          expected_next = '0;
        end else begin
          expected_next = bus.column_seg + 4'd1;
        end
      end
    end else if (state == CAPTURE) begin
      if (tcnt == TLAST) begin
        stall_set     = 1'b1;
        tcnt_next     = '0;
        state_next    = IDLE;
        expected_next = '0;
      end else begin
        tcnt_next = tcnt + TW'(1);
      end
    end
  end

  // Sequencer registers: state, expected column, timeout counter, strobe history.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      expected  <= '0;
      tcnt      <= '0;
      col_clk_q <= 1'b0;
    end else begin
      state     <= state_next;
      expected  <= expected_next;
      tcnt      <= tcnt_next;
      col_clk_q <= bus.COLUMN_CLK;
    end
  end

  // Status: frame-done pulse, frame counter and sticky error flags (set beats clear).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      done_q  <= 1'b0;
      cnt_q   <= '0;
      seq_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      done_q  <= commit;
      if (commit) begin
        cnt_q <= cnt_q + 8'd1;
      end
      seq_q   <= seq_set   | (seq_q   & ~bus.ERR_CLR);
      stall_q <= stall_set | (stall_q & ~bus.ERR_CLR);
    end
  end

  // Frame stores and read port; the commit merges the final column on the fly,
  // and the read samples the committed buffer before the commit lands.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i]    <= '0;
        committed[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en) begin
        shadow[bus.column_seg] <= word;
      end
      if (commit) begin
        for (int i = 0; i < 16; i++) begin
          committed[i] <= (4'(i) == bus.column_seg) ? word : shadow[i];
        end
      end
      if ({1'b0, bus.rd_column} < NCOLS) begin
        rd_q <= committed[bus.rd_column];
      end else begin
        rd_q <= 16'h0000;
      end
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.frame_cnt  = cnt_q;
  assign bus.SEQ_ERR    = seq_q;
  assign bus.STALL      = stall_q;
  assign bus.BUSY       = (state == CAPTURE) && (expected != 4'd0);

endmodule

// File: doc/dot_matrix_scan_capture.md
Name: dot_matrix_scan_capture

Overview:
Receiving end of the 16x16 dot-matrix column-scan interface. Samples the scan outputs of the matrix driver (column select, column data, column strobe, clear) and rebuilds complete frames in a double-buffered 16x16 bit store. Complete frames are exposed through a registered read port, with frame-done, frame-count and error status. Used as a display-side capture model for bench checking of the driver, and as an on-chip loopback monitor.

Parameters:
COLS, 16, columns per frame; column_seg values 0..COLS-1 are valid, COLS <= 16.
TIMEOUT, 1024, CLK cycles without a COLUMN_CLK rising edge before a partial frame is abandoned.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RESET  input  1  asynchronous, active-high reset.
column_seg  input  4  column index from the driver, synchronous to CLK.
in_column  input  16  column pixel data from the driver, bit n = row n.
COLUMN_CLK  input  1  column strobe from the driver, level signal sampled on CLK.
OUT_CLR  input  1  driver blanking, active-high.
ERR_CLR  input  1  synchronous clear of SEQ_ERR and STALL.
rd_column  input  4  read address into the committed frame.
rd_data  output  16  committed frame column at rd_column, registered.
FRAME_DONE  output  1  one-cycle pulse when a frame commits.
frame_cnt  output  8  committed-frame count, wraps 255->0.
SEQ_ERR  output  1  sticky flag: out-of-order or out-of-range column.
STALL  output  1  sticky flag: strobe timeout during a partial frame.
BUSY  output  1  high while a frame is being assembled (state CAPTURE).

Behaviour:
- Reset (async): state IDLE; shadow and committed buffers all zero; rd_data=0; FRAME_DONE=0; frame_cnt=0; SEQ_ERR=0; STALL=0; BUSY=0; strobe edge register=0; timeout counter=0.
- Strobe: col_clk_q registers COLUMN_CLK. Event = COLUMN_CLK & ~col_clk_q. column_seg, in_column and OUT_CLR are sampled in the same cycle as the event.
- Captured word = OUT_CLR ? 16'h0000 : in_column.
- State IDLE:
  - Event with column_seg==0: write the word to shadow[0], set expected=1, go to CAPTURE.
  - Event with any other column_seg: ignore it; no error is raised (resync).
- State CAPTURE:
  - Event with column_seg==expected: write the word to shadow[column_seg] and increment expected.
  - If that column is COLS-1: copy shadow to the committed buffer in the same cycle, pulse FRAME_DONE next cycle, increment frame_cnt, set expected=0 and stay in CAPTURE. Back-to-back frames need no IDLE pass.
  - Event with column_seg!=expected, or column_seg>=COLS: set SEQ_ERR, discard the partial frame, go to IDLE. Exception: if column_seg==0, restart immediately, i.e. write shadow[0] and set expected=1 in CAPTURE.
- Timeout: counter clears on every event and counts in CAPTURE otherwise. Reaching TIMEOUT-1 sets STALL, clears the counter and goes to IDLE. The counter is held at 0 in IDLE.
- BUSY = (state==CAPTURE) and expected!=0. It is low in the cycle after a commit.
- Read: rd_data <= committed[rd_column] every cycle, 1-cycle latency.
  - rd_column>=COLS returns 16'h0000.
  - Commit and read in the same cycle: rd_data shows old data; new data appears the next cycle.
- ERR_CLR clears SEQ_ERR and STALL. If a new error is set in the same cycle, the error wins.
- RESET mid-frame: partial frame lost; committed buffer also cleared to zero.
- frame_cnt wraps from 255 to 0 without a flag.

Test Plan:
- Ordered frame: 16 strobes, column_seg 0..15, in_column=16'h0001<<column_seg, 4 CLK between strobes -> one FRAME_DONE pulse; frame_cnt=1; reading rd_column=5 gives rd_data=16'h0020 one cycle later; BUSY low after the commit.
- Blanking: same frame with OUT_CLR=1 on column 3 -> committed[3]=16'h0000; other columns unchanged.
- Out-of-order: columns 0,1,2,4 -> SEQ_ERR=1 after the 4th strobe; no FRAME_DONE; committed buffer still holds the previous frame. Then ERR_CLR pulse -> SEQ_ERR=0. Then a full 0..15 frame commits with frame_cnt incremented.
- Timeout: TIMEOUT=16, strobes 0..7, then no strobe for 16 cycles -> STALL=1, BUSY=0. A later column_seg=9 strobe is ignored with no SEQ_ERR.
- Back-to-back and wrap: 256 consecutive frames with no idle gap -> 256 FRAME_DONE pulses, frame_cnt=0. Read of the committed column during the commit cycle returns old data, then new data the next cycle.
- Async reset mid-frame: RESET asserted between columns 7 and 8 -> all outputs 0 immediately. A following frame starting at column 0 commits normally.
